// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_pkg
// Description : Shared definitions for the data-side memory/I-O bus:
//               memory-map constants and the UART transmitter state type.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

  // Memory map (byte addresses). Decode uses bits [15:2] only.
  localparam logic [15:0] RAM_BASE       = 16'h0000;
  localparam logic [15:0] ADDR_LED       = 16'h8000;
  localparam logic [15:0] ADDR_TIMER     = 16'h8004;
  localparam logic [15:0] ADDR_UART_TX   = 16'h8008;
  localparam logic [15:0] ADDR_UART_STAT = 16'h800C;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : 8N1 serial transmitter. A start pulse in IDLE latches the
//               byte and sends start bit, 8 data bits LSB first, stop bit,
//               each held CLKS_PER_BIT cycles. Starts while busy are ignored.
// Ports       : clk, rst (sync, active-high), start, data[7:0] -> tx, busy
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);
  import bus_pkg::*;

  localparam int          CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  uart_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          tx_q, tx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = START;
          cnt_d   = '0;
          bit_d   = '0;
          shreg_d = data;
        end
      end
      START: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d = '0;
          if (bit_q == 3'd7) state_d = STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The line level is registered from the next state so the start bit
  // appears on the same edge that accepts the write, without glitches.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);

endmodule
`default_nettype wire

// File: rtl/data_mem_bus.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_bus
// Description : Data-side bus for a single-cycle core: word RAM, LED
//               register, free-running timer and UART transmitter, with a
//               combinational read path.
// Ports       : clk, rst (sync, active-high), WE, address[15:0],
//               writeData[31:0] -> readData[31:0], leds[7:0], uart_tx
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_bus #(
  parameter int RAM_WORDS    = 1024,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WE,
  input  logic [15:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic [7:0]  leds,
  output logic        uart_tx
);
  import bus_pkg::*;

  localparam int          AW          = $clog2(RAM_WORDS);
  localparam logic [13:0] RAM_WORDS_W = 14'(RAM_WORDS);

  logic [31:0]   mem [RAM_WORDS];
  logic [13:0]   ram_off;
  logic [AW-1:0] ram_idx;
  logic          ram_sel, led_sel, tmr_sel, utx_sel, ust_sel;
  logic          wr_en, uart_start, uart_busy;
  logic [31:0]   timer;
  logic [7:0]    tx_byte;
  logic          unused_addr_lsbs;

  // Byte lanes are not supported; the low address bits carry no meaning.
  assign unused_addr_lsbs = ^address[1:0];

  assign ram_off = address[15:2] - RAM_BASE[15:2];
  assign ram_idx = ram_off[AW-1:0];
  assign ram_sel = (ram_off < RAM_WORDS_W);
  assign led_sel = (address[15:2] == ADDR_LED[15:2]);
  assign tmr_sel = (address[15:2] == ADDR_TIMER[15:2]);
  assign utx_sel = (address[15:2] == ADDR_UART_TX[15:2]);
  assign ust_sel = (address[15:2] == ADDR_UART_STAT[15:2]);

  // Stores presented while reset is asserted are discarded everywhere.
  assign wr_en      = WE && !rst;
  assign uart_start = wr_en && utx_sel && !uart_busy;

  always_ff @(posedge clk) begin
    if (wr_en && ram_sel) mem[ram_idx] <= writeData;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      leds    <= '0;
      timer   <= '0;
      tx_byte <= '0;
    end else begin
      if (wr_en && led_sel) leds <= writeData[7:0];
      timer <= (wr_en && tmr_sel) ? writeData : timer + 32'd1;
      if (uart_start) tx_byte <= writeData[7:0];
    end
  end

  always_comb begin
    readData = '0;
    if (ram_sel)      readData = mem[ram_idx];
    else if (led_sel) readData = {24'b0, leds};
    else if (tmr_sel) readData = timer;
    else if (utx_sel) readData = {24'b0, tx_byte};
    else if (ust_sel) readData = {31'b0, uart_busy};
  end

  uart_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart (
    .clk  (clk),
    .rst  (rst),
    .start(uart_start),
    .data (writeData[7:0]),
    .tx   (uart_tx),
    .busy (uart_busy)
  );

endmodule
`default_nettype wire

// File: doc/data_mem_bus.md
# data_mem_bus

Data-side memory and I/O bus consumed directly downstream of the `rv32i` core. It decodes the core's `address` / `writeData` / `WE` outputs and returns `readData` in the same cycle, as the single-cycle core requires. It contains:
- a word-addressed data RAM;
- an LED output register;
- a free-running cycle timer;
- an 8N1 UART transmitter with its own bit-timing state machine.

## Interface
- `RAM_WORDS`, 1024: data RAM depth in 32-bit words (power of two, ≤ 8192).
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `WE`  in  1  store enable from the core.
- `address`  in  16  byte address from the core; bits [1:0] are ignored (word accesses only).
- `writeData`  in  32  store data from the core.
- `readData`  out  32  load data to the core; combinational from `address`.
- `leds`  out  8  LED register.
- `uart_tx`  out  1  serial output; idle high.

## Operation
Memory map (decode on `address[15:2]`):
- 0x0000–(4·RAM_WORDS−1), RAM:
  - index `address[log2(RAM_WORDS)+1:2]`;
  - read is asynchronous;
  - write is 32-bit and happens on the edge when `WE`=1.
- 0x8000, LED:
  - read `{24'b0, leds}`;
  - write loads `writeData[7:0]`.
- 0x8004, TIMER:
  - 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF→0;
  - a write loads `writeData`, and the write wins over the increment.
- 0x8008, UART_TX:
  - write while idle latches `writeData[7:0]` and starts a frame;
  - write while busy is silently dropped;
  - read returns `{24'b0, last latched byte}`.
- 0x800C, UART_STAT:
  - read `{31'b0, busy}`;
  - writes are ignored.
- Any other address: reads return 0; writes have no effect.

UART FSM (states IDLE, START, DATA, STOP):
- IDLE:
  - `uart_tx`=1 and busy=0;
  - an accepted write goes to START with the bit counter cleared.
- START: `uart_tx`=0 for `CLKS_PER_BIT` cycles, then DATA.
- DATA:
  - 8 bits, LSB first, each held `CLKS_PER_BIT` cycles;
  - after bit 7, go to STOP.
- STOP: `uart_tx`=1 for `CLKS_PER_BIT` cycles, then IDLE.
- busy=1 in every state except IDLE.
- Baud counter: reloads at each bit boundary; width is `$clog2(CLKS_PER_BIT)`.

## Timing
- `readData` is valid in the same cycle as `address`, with zero latency.
- Writes become visible to reads in the cycle after the `WE` edge. A same-cycle read returns the old value.
- UART start:
  - a write accepted on edge N drives `uart_tx` low from edge N;
  - the full frame lasts 10·`CLKS_PER_BIT` cycles;
  - busy reads 1 in the cycle after edge N.
- Earliest back-to-back frame: a write in the cycle after STOP completes (busy=0) is accepted, with no extra idle cycles.
- Reset values: `leds`=0, TIMER=0, UART state IDLE, `uart_tx`=1, latched byte 0. RAM contents are not reset.
- Reset mid-frame: the FSM aborts to IDLE and `uart_tx` goes high on the reset edge. A write during reset is ignored.
- TIMER reads in the reset cycle's successor return 0, then increment by 1 per cycle.

## Structure
Shared package `bus_pkg`:
- address constants `ADDR_LED`, `ADDR_TIMER`, `ADDR_UART_TX`, `ADDR_UART_STAT`, `RAM_BASE`;
- UART state enum `uart_state_t`.

Sub-module `uart_tx`:
- inputs: clk, rst, start, data[7:0];
- outputs: tx, busy;
- parameter `CLKS_PER_BIT`.

The top level holds the RAM, the decode, the LED/TIMER registers and the `readData` mux.

## Test plan
1. RAM:
   - write 0xDEADBEEF to 0x0010, then read 0x0010 and 0x0013 → both return 0xDEADBEEF;
   - read 0x0014 → returns the unwritten word, unaffected by the write.
2. LED / unmapped:
   - write 0x1A5 to 0x8000 → `leds`=0xA5, and reading 0x8000 returns 0x000000A5;
   - write to 0x9000 → no state change, and reading it returns 0.
3. Timer:
   - after reset, read 0x8004 five cycles later → returns 5;
   - write 0xFFFFFFFE → reads 0xFFFFFFFE, then 0xFFFFFFFF, then 0 on successive cycles.
4. UART frame, with `CLKS_PER_BIT`=4:
   - write 0x55 to 0x8008 → `uart_tx` sequence, 4 cycles each: 0,1,0,1,0,1,0,1,0,1;
   - status reads 1 throughout and 0 after 40 cycles.
5. UART busy drop: write 0x41, then write 0x42 mid-frame → only the 0x41 frame is transmitted, and 0x8008 reads 0x41.
6. Reset mid-frame: assert `rst` during DATA bit 3 → `uart_tx`=1 and busy=0 the next cycle; `leds`=0 and TIMER=0.
